// File: rtl/data_mem_ctrl_pkg.sv
// Shared types for the data-side memory controller: FSM states, access size codes
// and the alignment rule used both for issue gating and address-error reporting.
package data_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Bytes are always aligned; an unused size code is treated like a byte here.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_WORD: bad = (lsb != 2'b00);
      SZ_HALF: bad = lsb[0];
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_load_data_ext.sv
// Load result formatter: picks the addressed byte/half lane out of the bus word
// and sign- or zero-extends it; words pass through untouched.
module load_data_ext
  import data_mem_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[7:0];
    case (addr)
      2'd0: byte_lane = rdata[7:0];
      2'd1: byte_lane = rdata[15:8];
      2'd2: byte_lane = rdata[23:16];
      2'd3: byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = rdata;
    case (size)
      SZ_BYTE: result = {{24{sign & byte_lane[7]}}, byte_lane};
      SZ_HALF: result = {{16{sign & half_lane[15]}}, half_lane};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data bus controller: alignment check, req/addr_ok/data_ok handshake,
// pipeline stall generation, flush cancellation and load data formatting.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [1:0]        mem_size,
  input  logic              mem_sign,
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_hold,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic              adel,
  output logic              ades
);

  state_t      state;
  state_t      state_nxt;
  logic        cancel;
  logic        cancel_nxt;
  logic        cancel_now;
  logic        lat_sign;
  logic        latch_en;
  logic        capture;
  logic        misaligned;
  logic        access;
  logic        stall_raw;
  logic [31:0] ext_result;

  assign misaligned = is_misaligned(mem_size, mem_addr[1:0]);
  assign adel       = mem_rd & misaligned;
  assign ades       = mem_wr & misaligned;
  assign access     = (mem_rd | mem_wr) & ~misaligned & ~flush;
  // A flush landing in the completing cycle is treated like an earlier one.
  assign cancel_now = cancel | flush;

  assign data_req = (state == ST_REQ);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      cancel <= 1'b0;
    end else begin
      state  <= state_nxt;
      cancel <= cancel_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cancel_nxt = cancel;
    latch_en   = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access) begin
          latch_en  = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (flush) cancel_nxt = 1'b1;
        if (data_addr_ok) begin
          if (!data_data_ok) begin
            state_nxt = ST_WAIT;
          end else if (cancel_now) begin
            state_nxt  = ST_IDLE;
            cancel_nxt = 1'b0;
          end else begin
            state_nxt = ST_DONE;
            capture   = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (flush) cancel_nxt = 1'b1;
        if (data_data_ok) begin
          if (cancel_now) begin
            state_nxt  = ST_IDLE;
            cancel_nxt = 1'b0;
          end else begin
            state_nxt = ST_DONE;
            capture   = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!mem_hold || flush) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // While a cancelled transfer drains, only a newly arrived access keeps the pipe stalled.
  always_comb begin
    stall_raw = 1'b0;
    case (state)
      ST_IDLE:          stall_raw = access;
      ST_REQ, ST_WAIT:  stall_raw = (~cancel & ~flush) | access;
      default:          stall_raw = 1'b0;
    endcase
    mem_stall = resetn & stall_raw;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_wr    <= 1'b0;
      data_size  <= 2'b00;
      data_addr  <= '0;
      data_wdata <= '0;
      data_wstrb <= 4'b0000;
      lat_sign   <= 1'b0;
    end else if (latch_en) begin
      data_wr    <= mem_wr;
      data_size  <= mem_size;
      data_addr  <= mem_addr;
      data_wdata <= mem_wdata;
      data_wstrb <= mem_wr ? mem_sel : 4'b0000;
      lat_sign   <= mem_sign;
    end
  end

  load_data_ext u_load_data_ext (
    .rdata  (data_rdata),
    .addr   (data_addr[1:0]),
    .size   (data_size),
    .sign   (lat_sign),
    .result (ext_result)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_rdata <= '0;
    end else if (capture && !data_wr) begin
      mem_rdata <= ext_result;
    end
  end

endmodule
